// File: rtl/uart_rx_monitor.sv
// Purpose: 8N1 UART receiver with a first-word fall-through byte buffer and error pulses.
// Latency: o_valid rises ~9.5 bit times + 3 clk after the start-bit falling edge (stop-bit mid-sample + 1).
// Backpressure: i_ready low holds the head byte; a good byte arriving while the buffer is full is dropped (o_overflow).
//
// Ports:
//   clk, rstn           - single clock, async active-low reset
//   i_rx                - asynchronous serial line, idle high, LSB first
//   o_data/o_valid      - buffer head byte and non-empty flag
//   i_ready             - consumer pops the head when o_valid && i_ready
//   o_frame_err         - one-cycle pulse: stop bit sampled low, byte discarded
//   o_overflow          - one-cycle pulse: good byte dropped because buffer full
//   o_busy              - receiver is inside a frame (not IDLE)
module uart_rx_monitor #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overflow,
    output logic       o_busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ------------------------------------------------------------------
    // Line synchronizer; rx_prev gives the 1->0 edge used to arm a frame,
    // so after a framing error the line must go high before re-arming.
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx;
    logic rx_prev;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rx      <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx      <= rx_meta;
            rx_prev <= rx;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t          state;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            timer       <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_frame_err <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx) begin
                        state  <= START;
                        timer  <= T_HALF;
                        o_busy <= 1'b1;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        if (rx) begin
                            // Glitch shorter than half a bit: not a real start.
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end else begin
                            state   <= DATA;
                            timer   <= T_FULL;
                            bit_idx <= '0;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        shift[bit_idx] <= rx;
                        timer          <= T_FULL;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                        if (!rx) begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

    // Good stop bit: byte is handed to the buffer on the stop-sample edge.
    logic push;
    assign push = (state == STOP) && (timer == '0) && rx;

    // ------------------------------------------------------------------
    // FWFT buffer; pointers carry one extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [7:0]   mem [FIFO_DEPTH];
    logic         empty;
    logic         full;
    logic         pop;
    logic         wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && i_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    assign wr_en = push && (!full || pop);

    assign o_valid = !empty;
    assign o_data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            o_overflow <= push && full && !pop;
            if (wr_en) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: doc/uart_rx_monitor.md
UART_RX_MONITOR -- requirements
Module: uart_rx_monitor

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (50 MHz / 115200); legal values are 8 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive buffer entries; legal values are a power of two, 2 or more.
REQ-003 SHALL have port clk  input  1  the single clock; all logic rises on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port i_rx  input  1  serial line, asynchronous to clk; idles high; 8N1 framing, LSB first.
REQ-006 SHALL have port o_data  output  8  received byte at the FIFO head.
REQ-007 SHALL have port o_valid  output  1  FIFO non-empty; o_data is valid.
REQ-008 SHALL have port i_ready  input  1  consumer accepts the head byte when o_valid and i_ready are both high.
REQ-009 SHALL have port o_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port o_overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-011 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-012 SHALL pass i_rx through a 2-flop synchronizer with reset value 1; all references to "rx" below mean the synchronized signal.
REQ-013 SHALL implement states IDLE, START, DATA and STOP, plus a bit-timer counter and a 3-bit bit index.
REQ-014 In IDLE, SHALL enter START on a rx 1->0 transition and load the timer with CLKS_PER_BIT/2-1 (integer division).
REQ-015 In START, when the timer reaches 0, SHALL sample rx:
- rx=1: false start; SHALL return to IDLE with no output.
- rx=0: SHALL enter DATA with the timer at CLKS_PER_BIT-1 and the bit index at 0.
REQ-016 In DATA, each time the timer reaches 0, SHALL shift rx into shift-register bit[index] (LSB first) and reload the timer with CLKS_PER_BIT-1; after index 7 it SHALL enter STOP.
REQ-017 In STOP, when the timer reaches 0, SHALL sample rx and return to IDLE:
- rx=1: push the byte.
- rx=0: pulse o_frame_err and discard the byte.
REQ-018 After a framing error, SHALL require rx to be seen high before the next start bit; this follows from the edge detection in REQ-014.
REQ-019 On a push, o_valid SHALL be high on the cycle after the stop-sample cycle if the FIFO was empty.
REQ-020 On a push while the FIFO is full and no pop occurs in the same cycle, SHALL drop the new byte, keep the FIFO contents unchanged and pulse o_overflow.
REQ-021 On a push and pop in the same cycle while full, SHALL perform both operations with no overflow.
REQ-022 The FIFO SHALL be first-word fall-through:
- o_data SHALL equal the oldest entry while o_valid is high.
- o_data SHALL hold steady while o_valid is high and i_ready is low.
REQ-023 The FIFO read/write pointers SHALL be log2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH; full and empty SHALL be distinguished by the pointer MSB.
REQ-024 SHALL tolerate a sender baud error of at least ±2% without bit errors.

Reset
REQ-025 While rstn is low:
- state SHALL be IDLE, with timer, bit index and shift register at 0.
- FIFO pointers SHALL be 0.
- synchronizer flops SHALL be 1.
- outputs SHALL be o_valid=0, o_data=0, o_frame_err=0, o_overflow=0, o_busy=0.
REQ-026 Reset asserted in the middle of a frame SHALL abort the frame with no output.
REQ-027 After reset release, the remaining bits of an aborted frame SHALL NOT produce a byte unless they form a valid start-to-stop frame.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-028 Send 0xA5 with i_ready=1 -> o_valid pulses for one cycle with o_data=0xA5, 2+8+9*16 (±1) cycles after the falling edge on i_rx; o_busy drops on that same cycle.
REQ-029 Pull i_rx low for 4 cycles only -> no o_valid and no o_frame_err; o_busy returns low within 12 cycles.
REQ-030 Send 0x3C with the stop bit forced low -> o_frame_err pulses exactly once and o_valid stays 0; then a following 0x5A is received correctly.
REQ-031 Hold i_ready=0 and send 0x01..0x05 -> o_overflow pulses once, on byte 0x05; then raise i_ready -> o_data reads 0x01, 0x02, 0x03, 0x04 in order, after which o_valid=0.
REQ-032 Assert rstn low during bit 3 of 0xFF, then release it while i_rx is high -> all outputs are 0 during reset; then 0x81 is received correctly.
REQ-033 Send 0x00 and 0xFF back-to-back with no idle gap, using senders at +2% and -2% baud -> both bytes are received intact.
